stm_segment_swapper: RTL and testbench

Sits directly downstream of `stm_timer` and consumes both of its per-segment indices (`IDX[0]`, `IDX[1]`). It selects which segment is active and applies a segment-switch request either immediately or at the end of the current loop. It counts completed loops against a finite repetition budget and freezes the index when the budget is spent. Its outputs, one active segment and one index, drive the STM BRAM read address and the segment select.

---
 rtl/stm_segment_swapper_if.sv | 28 ++
 rtl/stm_segment_swapper.sv | 100 ++++++++++
 tb/tb_stm_segment_swapper.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stm_segment_swapper_if.sv
// Settings/index bus between the stm_timer side and the segment swapper.
// UPDATE_SETTINGS_IN is a one-cycle valid with no ready: the swapper accepts every pulse.
interface stm_segment_swapper_if #(
    parameter int IdxWidth = 13,
    parameter int RepWidth = 16
);
    logic                     UPDATE_SETTINGS_IN;
    logic                     REQ_RD_SEGMENT;
    logic                     TRANSITION_MODE;
    logic [1:0][RepWidth-1:0] REP;
    logic [1:0][IdxWidth-1:0] CYCLE;
    logic [1:0][IdxWidth-1:0] IDX_IN;
    logic                     SEGMENT;
    logic [IdxWidth-1:0]      IDX_OUT;
    logic                     STOP;
    logic                     UPDATE_SETTINGS_OUT;
    logic [1:0]               STATE_DBG;

    modport master (
        output UPDATE_SETTINGS_IN, REQ_RD_SEGMENT, TRANSITION_MODE, REP, CYCLE, IDX_IN,
        input  SEGMENT, IDX_OUT, STOP, UPDATE_SETTINGS_OUT, STATE_DBG
    );

    modport slave (
        input  UPDATE_SETTINGS_IN, REQ_RD_SEGMENT, TRANSITION_MODE, REP, CYCLE, IDX_IN,
        output SEGMENT, IDX_OUT, STOP, UPDATE_SETTINGS_OUT, STATE_DBG
    );
endinterface

// File: rtl/stm_segment_swapper.sv
// Chooses the active STM segment, applies immediate or end-of-loop switches,
// and freezes the index once the active segment's loop budget is spent.
module stm_segment_swapper #(
    parameter int IdxWidth = 13,
    parameter int RepWidth = 16
) (
    input logic                  CLK,
    input logic                  RST,
    stm_segment_swapper_if.slave bus
);
    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_WAIT_WRAP = 2'd1;
    localparam logic [1:0] ST_STOPPED   = 2'd2;

    localparam logic [RepWidth-1:0] REP_INF = '1;

    logic [1:0]               state;
    logic                     segment;
    logic                     req_seg;
    logic                     stop;
    logic                     upd_out;
    logic [IdxWidth-1:0]      idx_out;
    logic [RepWidth-1:0]      loop_cnt;
    logic [RepWidth-1:0]      loop_next;
    logic [1:0][RepWidth-1:0] rep;
    logic [1:0][IdxWidth-1:0] cycle;
    logic [1:0][IdxWidth-1:0] prev_idx;
    logic [1:0]               wrap;
    logic                     wrap_act;
    logic                     budget_done;
    logic                     switch_now;

    // A zero-length segment never wraps, which makes its budget infinite.
    assign wrap[0] = (bus.IDX_IN[0] == '0) && (prev_idx[0] != '0) && (cycle[0] != '0);
    assign wrap[1] = (bus.IDX_IN[1] == '0) && (prev_idx[1] != '0) && (cycle[1] != '0);

    assign wrap_act    = wrap[segment];
    assign budget_done = (rep[segment] != REP_INF) && (loop_cnt == rep[segment]);
    assign loop_next   = (loop_cnt == '1) ? loop_cnt : loop_cnt + 1'b1;
    assign switch_now  = (bus.REQ_RD_SEGMENT == segment) || !bus.TRANSITION_MODE ||
                         (state == ST_STOPPED);

    always_ff @(posedge CLK) begin
        prev_idx <= bus.IDX_IN;
        if (RST) begin
            state    <= ST_RUN;
            segment  <= 1'b0;
            req_seg  <= 1'b0;
            stop     <= 1'b0;
            upd_out  <= 1'b0;
            idx_out  <= '0;
            loop_cnt <= '0;
            rep      <= {REP_INF, REP_INF};
            cycle    <= '0;
        end else begin
            upd_out <= 1'b0;
            if (bus.UPDATE_SETTINGS_IN) begin
                // A request always beats a wrap seen on the same cycle.
                req_seg <= bus.REQ_RD_SEGMENT;
                rep     <= bus.REP;
                cycle   <= bus.CYCLE;
                if (switch_now) begin
                    segment  <= bus.REQ_RD_SEGMENT;
                    idx_out  <= bus.IDX_IN[bus.REQ_RD_SEGMENT];
                    loop_cnt <= '0;
                    stop     <= 1'b0;
                    upd_out  <= 1'b1;
                    state    <= ST_RUN;
                end else begin
                    idx_out <= bus.IDX_IN[segment];
                    state   <= ST_WAIT_WRAP;
                end
            end else if (state != ST_STOPPED) begin
                if (wrap_act && state == ST_WAIT_WRAP) begin
                    // Pending switch takes priority over an expiring budget.
                    segment  <= req_seg;
                    idx_out  <= bus.IDX_IN[req_seg];
                    loop_cnt <= '0;
                    upd_out  <= 1'b1;
                    state    <= ST_RUN;
                end else if (wrap_act && budget_done) begin
                    idx_out <= cycle[segment];
                    stop    <= 1'b1;
                    state   <= ST_STOPPED;
                end else begin
                    idx_out <= bus.IDX_IN[segment];
                    if (wrap_act) begin
                        loop_cnt <= loop_next;
                    end
                end
            end
        end
    end

    assign bus.SEGMENT             = segment;
    assign bus.IDX_OUT             = idx_out;
    assign bus.STOP                = stop;
    assign bus.UPDATE_SETTINGS_OUT = upd_out;
    assign bus.STATE_DBG           = state;
endmodule

// File: tb/tb_stm_segment_swapper.sv
// Bench for stm_segment_swapper: emulated stm_timer indices, directed phases plus a
// random phase, every output compared each cycle against a loop-counting reference model.
module tb_stm_segment_swapper;
    localparam int IW  = 13;
    localparam int RW  = 16;
    localparam int INF = 65535;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    stm_segment_swapper_if #(.IdxWidth(IW), .RepWidth(RW)) bus ();

    stm_segment_swapper #(.IdxWidth(IW), .RepWidth(RW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Emulated stm_timer: counter 0..tcyc, advancing every tdiv+1 cycles.
    int tcyc[2];
    int tdiv[2];
    int tcnt[2];
    int tpre[2];

    // Reference model: which segment plays, how many loops it has completed,
    // whether a switch waits for the next loop end, and whether playback is frozen.
    bit m_seg;
    bit m_stop;
    bit m_upd;
    bit m_pending;
    int m_idx;
    int m_loops;
    int m_rep[2];
    int m_cyc[2];
    int m_prev[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic drive_timers();
        for (int s = 0; s < 2; s++) begin
            bus.IDX_IN[s] = IW'(tcnt[s]);
            bus.CYCLE[s]  = IW'(tcyc[s]);
        end
    endtask

    task automatic advance_timers();
        for (int s = 0; s < 2; s++) begin
            if (tpre[s] >= tdiv[s]) begin
                tpre[s] = 0;
                tcnt[s] = (tcnt[s] >= tcyc[s]) ? 0 : tcnt[s] + 1;
            end else begin
                tpre[s] = tpre[s] + 1;
            end
        end
        drive_timers();
    endtask

    task automatic tick();
        int ix[2];
        int rp[2];
        int cy[2];
        bit r;
        bit u;
        bit rs;
        bit md;
        bit w;
        r  = RST;
        u  = bus.UPDATE_SETTINGS_IN;
        rs = bus.REQ_RD_SEGMENT;
        md = bus.TRANSITION_MODE;
        for (int s = 0; s < 2; s++) begin
            ix[s] = int'(bus.IDX_IN[s]);
            rp[s] = int'(bus.REP[s]);
            cy[s] = int'(bus.CYCLE[s]);
        end
        @(posedge CLK);
        #1;
        m_upd = 1'b0;
        if (r) begin
            m_seg     = 1'b0;
            m_stop    = 1'b0;
            m_pending = 1'b0;
            m_idx     = 0;
            m_loops   = 0;
            m_rep     = '{INF, INF};
            m_cyc     = '{0, 0};
        end else if (u) begin
            m_rep = rp;
            m_cyc = cy;
            if (rs == m_seg || !md || m_stop) begin
                m_seg     = rs;
                m_loops   = 0;
                m_stop    = 1'b0;
                m_pending = 1'b0;
                m_upd     = 1'b1;
            end else begin
                m_pending = 1'b1;
            end
            m_idx = ix[m_seg];
        end else if (!m_stop) begin
            w = (ix[m_seg] == 0) && (m_prev[m_seg] != 0) && (m_cyc[m_seg] != 0);
            if (w && m_pending) begin
                m_seg     = !m_seg;
                m_pending = 1'b0;
                m_loops   = 0;
                m_upd     = 1'b1;
                m_idx     = ix[m_seg];
            end else if (w && m_rep[m_seg] != INF && m_loops == m_rep[m_seg]) begin
                m_stop = 1'b1;
                m_idx  = m_cyc[m_seg];
            end else begin
                if (w && m_loops < INF) m_loops++;
                m_idx = ix[m_seg];
            end
        end
        m_prev = ix;
        check("segment", 32'(bus.SEGMENT), 32'(m_seg));
        check("idx_out", 32'(bus.IDX_OUT), 32'(m_idx));
        check("stop", 32'(bus.STOP), 32'(m_stop));
        check("update_out", 32'(bus.UPDATE_SETTINGS_OUT), 32'(m_upd));
        RST = 1'b0;
        bus.UPDATE_SETTINGS_IN = 1'b0;
        advance_timers();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic request(input bit seg, input bit mode, input int r0, input int r1);
        bus.REQ_RD_SEGMENT     = seg;
        bus.TRANSITION_MODE    = mode;
        bus.REP[0]             = RW'(r0);
        bus.REP[1]             = RW'(r1);
        bus.UPDATE_SETTINGS_IN = 1'b1;
        tick();
    endtask

    task automatic wait_idx(input int s, input int v, input int budget, input string tag);
        int n = 0;
        while (int'(bus.IDX_IN[s]) != v && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(int'(bus.IDX_IN[s]) == v), 32'd1);
    endtask

    // Stops when the coming edge will present a wrap of segment s.
    task automatic wait_wrap_next(input int s, input int budget, input string tag);
        int n = 0;
        while (!(int'(bus.IDX_IN[s]) == 0 && m_prev[s] != 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    function automatic int rnd_rep();
        return ($urandom_range(0, 3) == 0) ? INF : int'($urandom_range(0, 3));
    endfunction

    initial begin
        int n;
        bit bad;
        tcyc = '{8191, 999};
        tdiv = '{0, 3};
        tcnt = '{0, 0};
        tpre = '{0, 0};
        m_prev = '{0, 0};
        bus.UPDATE_SETTINGS_IN = 1'b0;
        bus.REQ_RD_SEGMENT     = 1'b0;
        bus.TRANSITION_MODE    = 1'b0;
        bus.REP[0]             = '1;
        bus.REP[1]             = '1;
        drive_timers();

        // Reset and pass-through of segment 0.
        repeat (3) begin
            RST = 1'b1;
            tick();
        end
        check("rst_segment", 32'(bus.SEGMENT), 32'd0);
        check("rst_stop", 32'(bus.STOP), 32'd0);
        run(300);

        // Immediate switch while segment 0 shows 4000.
        wait_idx(0, 4000, 9000, "reach_4000");
        request(1'b1, 1'b0, INF, INF);
        check("imm_segment", 32'(bus.SEGMENT), 32'd1);
        check("imm_pulse", 32'(bus.UPDATE_SETTINGS_OUT), 32'd1);
        run(200);

        // Sync switch requested while segment 0 shows 100.
        request(1'b0, 1'b0, INF, INF);
        wait_idx(0, 100, 9000, "reach_100");
        request(1'b1, 1'b1, INF, INF);
        n = 0;
        while (bus.SEGMENT === 1'b0 && n < 9000) begin
            tick();
            n++;
        end
        check("sync_switch_seen", 32'(bus.SEGMENT), 32'd1);
        bad = 1'b0;
        repeat (2000) begin
            tick();
            if (int'(bus.IDX_OUT) > 999) bad = 1'b1;
        end
        check("post_switch_range", 32'(bad), 32'd0);

        // Finite repetition: three loops of segment 1, then a frozen index.
        request(1'b1, 1'b0, INF, 2);
        n = 0;
        while (bus.STOP !== 1'b1 && n < 13000) begin
            tick();
            n++;
        end
        check("stop_reached", 32'(bus.STOP), 32'd1);
        run(2000 + int'($urandom_range(0, 200)));
        check("stop_hold_stop", 32'(bus.STOP), 32'd1);
        check("stop_hold_idx", 32'(bus.IDX_OUT), 32'd999);
        request(1'b0, 1'b1, INF, 2);
        check("resume_segment", 32'(bus.SEGMENT), 32'd0);
        check("resume_stop", 32'(bus.STOP), 32'd0);

        // Request on the same cycle as the terminating wrap.
        request(1'b1, 1'b0, INF, 0);
        wait_wrap_next(1, 5000, "wrap1_found");
        request(1'b0, 1'b0, INF, 0);
        check("collide_stop", 32'(bus.STOP), 32'd0);
        check("collide_segment", 32'(bus.SEGMENT), 32'd0);
        run(100);

        // Second request during WAIT_WRAP targeting the active segment clears the loop count.
        tcyc[0] = 511;
        tcnt[0] = 0;
        tpre[0] = 0;
        drive_timers();
        request(1'b0, 1'b0, INF, INF);
        run(1100);
        request(1'b1, 1'b1, 1, INF);
        run(50 + int'($urandom_range(0, 100)));
        request(1'b0, 1'b0, 1, INF);
        run(3 * 512 + 20);
        check("cleared_count_stop", 32'(bus.STOP), 32'd1);
        check("cleared_count_segment", 32'(bus.SEGMENT), 32'd0);

        // Reset while a sync switch is pending.
        request(1'b0, 1'b0, INF, INF);
        request(1'b1, 1'b1, INF, INF);
        run(20);
        RST = 1'b1;
        tick();
        check("midrst_segment", 32'(bus.SEGMENT), 32'd0);
        check("midrst_idx", 32'(bus.IDX_OUT), 32'd0);
        check("midrst_stop", 32'(bus.STOP), 32'd0);
        check("midrst_pulse", 32'(bus.UPDATE_SETTINGS_OUT), 32'd0);
        run(1200);
        check("midrst_no_switch", 32'(bus.SEGMENT), 32'd0);

        // Random requests and resets over short segments.
        tcyc = '{63, 99};
        tdiv = '{0, 1};
        tcnt = '{0, 0};
        tpre = '{0, 0};
        drive_timers();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                RST = 1'b1;
                tick();
            end else if ($urandom_range(0, 59) == 0) begin
                request(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rnd_rep(), rnd_rep());
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
